pipe_datapath: RTL and testbench
================================

Name: pipe_datapath

Overview:
Pipelined successor to the single-cycle datapath. Takes decoded ID-stage control and operands and runs them through registered EX, MEM and WB stages. It contains the register file, ALU, comparator, data memory and result mux, plus hazard detection and a load-use stall, so the fetch/decode front-end can issue one instruction per cycle. Branch flags and ALU result leave from EX for branch/jump resolution by the front-end.

Parameters:
A_WIDTH, 5, register address width (2**A_WIDTH registers, x0 hardwired zero)
D_WIDTH, 32, data/address width of all operands, PC, immediates and memory data

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
trigger  in  1  passed to data memory unchanged
id_valid  in  1  ID presents a real instruction this cycle
MemWrite, RegWrite  in  1 each  ID control
ALUctrl  in  4  ID ALU operation
ALUSrcA, ALUSrcB  in  1 each  operand selects (PC / ImmExt)
ResultSrc  in  2  00 ALU, 01 load data, 10 inc_PC, 11 zero
funct3_i  in  3  memory access size/sign
rs1, rs2, rd  in  A_WIDTH each  ID register addresses
ImmExt, PC_out, inc_PC  in  D_WIDTH each  ID immediate, PC, PC+4
flush  in  1  kill the ID-stage instruction (taken branch/jump resolved in EX)
id_stall  out  1  ID must hold its instruction this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ALUout  out  D_WIDTH  EX ALU result (branch/jump target)
Zero, Less, LessU  out  1 each  EX comparator flags on forwarded rs1/rs2 values
wb_valid  out  1  WB retiring a real instruction
wb_rd  out  A_WIDTH  WB destination
a0  out  D_WIDTH  register x10

Behaviour:
- Stages: ID/EX, EX/MEM, MEM/WB registers, each with a valid bit. Bubble = valid 0, all write enables 0.
- Edge with id_valid & !id_stall & !flush: ID/EX loads the instruction. With id_stall or flush or !id_valid: ID/EX loads a bubble. EX/MEM and MEM/WB always advance.
- Latency: accepted at edge N: EX in cycle N+1, MEM N+2, WB N+3. Register written at the edge ending N+3. wb_valid is high in cycle N+3.
- Register read in ID is write-through: if WB writes rd==rs (rd!=0) in the same cycle, ID/EX captures the WB Result.
- x0: writes ignored. Reads return 0. Never a forwarding or hazard source.
- Load-use: EX instr valid, ResultSrc==01, RegWrite, rd!=0, and rd==rs1 or rd==rs2 of the valid ID instr -> id_stall=1. rs2 is compared regardless of instruction format; conservative false stalls are permitted.
- flush and id_stall together: flush wins. ID/EX gets a bubble, and id_stall is still driven (harmless).
- Data memory: write at MEM edge using the forwarded rd2 captured in EX/MEM. Read is combinational from the EX/MEM address and funct3.
- ResultSrc 11 -> Result 0.
- Reset: all valid bits 0, pipeline fields 0, register file cleared, so a0=0. id_stall=0, ex_valid=0, wb_valid=0, wb_rd=0 the cycle after reset. Reset mid-operation discards all in-flight instructions, and no register or memory write occurs in the reset cycle.

Optional Feature:
DATAPATH_FWD_EN. Defined: EX operands are forwarded from EX/MEM (ALU result; inc_PC when ResultSrc 10) and MEM/WB (Result), with EX/MEM taking priority. Only the load-use stall remains.
Undefined: no forwarding. id_stall=1 whenever a valid EX or MEM instr with RegWrite and rd!=0 matches ID rs1/rs2. WB conflicts are covered by the write-through read.

Decomposition:
- Package datapath_pkg: ResultSrc enum, ALUctrl width constant, and typedef structs id_ex_t, ex_mem_t, mem_wb_t (valid plus fields).
- Sub-module hazard_unit: stall and forwarding select generation, both macro variants.
- Existing regfile (extended with reset and write-through), ALU, Comparator, datamemory and mux/mux4 are reused.

Test Plan:
- FWD_EN: addi x1,x0,5; add x2,x1,x1 back-to-back -> id_stall never 1, x2=10 at WB of the 2nd instruction.
- mem[0]=0x00001234; lw x3,0(x0); add x4,x3,x0 -> id_stall=1 for exactly one cycle, x4=0x1234.
- FWD_EN undefined: addi x1,x0,7; add x2,x1,x0 -> id_stall=1 for 2 cycles, x2=7.
- addi x0,x0,9; add x5,x0,x0 -> x5=0, no stall, no forwarding from x0.
- flush asserted together with a load-use stall -> bubble enters EX, no register write for the flushed instr, wb_valid low in its slot.
- rst pulsed while 3 instructions are in flight -> no register/memory writes, a0=0, wb_valid=0. The next issued addi x10,x0,3 gives a0=3 after 4 cycles.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the pipelined datapath: result/ALU encodings, forwarding selects,
// pipeline register layouts and the load byte/half extraction helper.
package datapath_pkg;

    localparam int DP_A_WIDTH = 5;
    localparam int DP_D_WIDTH = 32;
    localparam int ALU_CTRL_W = 4;
    localparam int MEM_AW     = 8;
    localparam int MEM_WORDS  = 2 ** MEM_AW;

    // The top word of data memory is a read-only view of the trigger input.
    localparam logic [MEM_AW-1:0] TRIGGER_IDX = '1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_ZERO = 2'b11
    } result_src_t;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memwrite;
        alu_op_t               aluctrl;
        logic                  alusrca;
        logic                  alusrcb;
        result_src_t           resultsrc;
        logic [2:0]            funct3;
        logic [DP_A_WIDTH-1:0] rs1;
        logic [DP_A_WIDTH-1:0] rs2;
        logic [DP_A_WIDTH-1:0] rd;
        logic [DP_D_WIDTH-1:0] rd1;
        logic [DP_D_WIDTH-1:0] rd2;
        logic [DP_D_WIDTH-1:0] imm;
        logic [DP_D_WIDTH-1:0] pc;
        logic [DP_D_WIDTH-1:0] inc_pc;
    } id_ex_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memwrite;
        result_src_t           resultsrc;
        logic [2:0]            funct3;
        logic [DP_A_WIDTH-1:0] rd;
        logic [DP_D_WIDTH-1:0] alu;
        logic [DP_D_WIDTH-1:0] wdata;
        logic [DP_D_WIDTH-1:0] inc_pc;
    } ex_mem_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic [DP_A_WIDTH-1:0] rd;
        logic [DP_D_WIDTH-1:0] result;
    } mem_wb_t;

    function automatic logic [DP_D_WIDTH-1:0] load_extend(
        input logic [2:0]            f3,
        input logic [DP_D_WIDTH-1:0] word,
        input logic [1:0]            byte_off
    );
        logic [DP_D_WIDTH-1:0] sh;
        sh = word >> {byte_off, 3'b000};
        case (f3)
            F3_B:    load_extend = {{(DP_D_WIDTH-8){sh[7]}}, sh[7:0]};
            F3_H:    load_extend = {{(DP_D_WIDTH-16){sh[15]}}, sh[15:0]};
            F3_BU:   load_extend = {{(DP_D_WIDTH-8){1'b0}}, sh[7:0]};
            F3_HU:   load_extend = {{(DP_D_WIDTH-16){1'b0}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// ID-stage stall and EX operand forwarding selects. With DATAPATH_FWD_EN only the
// load-use case stalls; without it every pending EX/MEM write to a source stalls.
module hazard_unit
    import datapath_pkg::*;
#(
    parameter int A_WIDTH = DP_A_WIDTH
) (
    input  logic               id_valid,
    input  logic [A_WIDTH-1:0] id_rs1,
    input  logic [A_WIDTH-1:0] id_rs2,
    input  logic               ex_valid,
    input  logic               ex_regwrite,
    input  result_src_t        ex_resultsrc,
    input  logic [A_WIDTH-1:0] ex_rd,
    input  logic [A_WIDTH-1:0] ex_rs1,
    input  logic [A_WIDTH-1:0] ex_rs2,
    input  logic               mem_valid,
    input  logic               mem_regwrite,
    input  logic [A_WIDTH-1:0] mem_rd,
    input  logic               wb_valid,
    input  logic               wb_regwrite,
    input  logic [A_WIDTH-1:0] wb_rd,
    output logic               id_stall,
    output fwd_sel_t           fwd_a,
    output fwd_sel_t           fwd_b
);

    logic ex_writes;
    logic mem_writes;
    logic wb_writes;

    assign ex_writes  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
    assign mem_writes = mem_valid & mem_regwrite & (mem_rd != '0);
    assign wb_writes  = wb_valid  & wb_regwrite  & (wb_rd  != '0);

`ifdef DATAPATH_FWD_EN
    logic ex_hit;

    assign ex_hit   = ex_writes & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign id_stall = id_valid & ex_hit & (ex_resultsrc == RES_LOAD);

    // The younger producer in EX/MEM wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (mem_writes && mem_rd == ex_rs1)
            fwd_a = FWD_MEM;
        else if (wb_writes && wb_rd == ex_rs1)
            fwd_a = FWD_WB;
        if (mem_writes && mem_rd == ex_rs2)
            fwd_b = FWD_MEM;
        else if (wb_writes && wb_rd == ex_rs2)
            fwd_b = FWD_WB;
    end
`else
    logic ex_hit;
    logic mem_hit;
    logic unused_fwd_inputs;

    assign ex_hit   = ex_writes  & ((ex_rd  == id_rs1) | (ex_rd  == id_rs2));
    assign mem_hit  = mem_writes & ((mem_rd == id_rs1) | (mem_rd == id_rs2));
    assign id_stall = id_valid & (ex_hit | mem_hit);

    assign fwd_a = FWD_NONE;
    assign fwd_b = FWD_NONE;

    assign unused_fwd_inputs = ^{ex_resultsrc, ex_rs1, ex_rs2, wb_writes};
`endif

endmodule

// File: rtl/pipe_datapath.sv
// Pipelined EX/MEM/WB datapath with register file, ALU, comparator and data memory.
// Build with DATAPATH_FWD_EN to enable EX operand forwarding (see hazard_unit).
module pipe_datapath
    import datapath_pkg::*;
#(
    parameter int A_WIDTH = DP_A_WIDTH,
    parameter int D_WIDTH = DP_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic               id_valid,
    input  logic               MemWrite,
    input  logic               RegWrite,
    input  logic [3:0]         ALUctrl,
    input  logic               ALUSrcA,
    input  logic               ALUSrcB,
    input  logic [1:0]         ResultSrc,
    input  logic [2:0]         funct3_i,
    input  logic [A_WIDTH-1:0] rs1,
    input  logic [A_WIDTH-1:0] rs2,
    input  logic [A_WIDTH-1:0] rd,
    input  logic [D_WIDTH-1:0] ImmExt,
    input  logic [D_WIDTH-1:0] PC_out,
    input  logic [D_WIDTH-1:0] inc_PC,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [D_WIDTH-1:0] ALUout,
    output logic               Zero,
    output logic               Less,
    output logic               LessU,
    output logic               wb_valid,
    output logic [A_WIDTH-1:0] wb_rd,
    output logic [D_WIDTH-1:0] a0
);

    localparam int NREG = 2 ** A_WIDTH;
    localparam int SH_W = $clog2(D_WIDTH);

    id_ex_t  id_ex,  id_ex_next;
    ex_mem_t ex_mem, ex_mem_next;
    mem_wb_t mem_wb, mem_wb_next;

    logic [D_WIDTH-1:0] regs [NREG];
    logic [D_WIDTH-1:0] dmem [MEM_WORDS];

    logic               wb_we;
    logic [D_WIDTH-1:0] rd1;
    logic [D_WIDTH-1:0] rd2;
    fwd_sel_t           fwd_a;
    fwd_sel_t           fwd_b;
    logic [D_WIDTH-1:0] exm_value;
    logic [D_WIDTH-1:0] rs1_val;
    logic [D_WIDTH-1:0] rs2_val;
    logic [D_WIDTH-1:0] srca;
    logic [D_WIDTH-1:0] srcb;
    logic [D_WIDTH-1:0] alu_y;
    logic [MEM_AW-1:0]  mem_idx;
    logic [1:0]         byte_off;
    logic [D_WIDTH-1:0] mem_word;
    logic [D_WIDTH-1:0] load_data;

    assign wb_we = mem_wb.valid & mem_wb.regwrite & (mem_wb.rd != '0);

    // Write-through read: a WB write to the same register is visible to ID this cycle.
    always_comb begin
        rd1 = regs[rs1];
        rd2 = regs[rs2];
        if (rs1 == '0)
            rd1 = '0;
        else if (wb_we && mem_wb.rd == rs1)
            rd1 = mem_wb.result;
        if (rs2 == '0)
            rd2 = '0;
        else if (wb_we && mem_wb.rd == rs2)
            rd2 = mem_wb.result;
    end

    always_comb begin
        id_ex_next           = '0;
        id_ex_next.valid     = 1'b1;
        id_ex_next.regwrite  = RegWrite;
        id_ex_next.memwrite  = MemWrite;
        id_ex_next.aluctrl   = alu_op_t'(ALUctrl);
        id_ex_next.alusrca   = ALUSrcA;
        id_ex_next.alusrcb   = ALUSrcB;
        id_ex_next.resultsrc = result_src_t'(ResultSrc);
        id_ex_next.funct3    = funct3_i;
        id_ex_next.rs1       = rs1;
        id_ex_next.rs2       = rs2;
        id_ex_next.rd        = rd;
        id_ex_next.rd1       = rd1;
        id_ex_next.rd2       = rd2;
        id_ex_next.imm       = ImmExt;
        id_ex_next.pc        = PC_out;
        id_ex_next.inc_pc    = inc_PC;
    end

    hazard_unit #(.A_WIDTH(A_WIDTH)) u_hazard (
        .id_valid     (id_valid),
        .id_rs1       (rs1),
        .id_rs2       (rs2),
        .ex_valid     (id_ex.valid),
        .ex_regwrite  (id_ex.regwrite),
        .ex_resultsrc (id_ex.resultsrc),
        .ex_rd        (id_ex.rd),
        .ex_rs1       (id_ex.rs1),
        .ex_rs2       (id_ex.rs2),
        .mem_valid    (ex_mem.valid),
        .mem_regwrite (ex_mem.regwrite),
        .mem_rd       (ex_mem.rd),
        .wb_valid     (mem_wb.valid),
        .wb_regwrite  (mem_wb.regwrite),
        .wb_rd        (mem_wb.rd),
        .id_stall     (id_stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // A load never forwards from EX/MEM: the load-use stall keeps its consumer out of EX.
    always_comb begin
        case (ex_mem.resultsrc)
            RES_PC4:  exm_value = ex_mem.inc_pc;
            RES_ZERO: exm_value = '0;
            default:  exm_value = ex_mem.alu;
        endcase
        case (fwd_a)
            FWD_MEM: rs1_val = exm_value;
            FWD_WB:  rs1_val = mem_wb.result;
            default: rs1_val = id_ex.rd1;
        endcase
        case (fwd_b)
            FWD_MEM: rs2_val = exm_value;
            FWD_WB:  rs2_val = mem_wb.result;
            default: rs2_val = id_ex.rd2;
        endcase
        srca = id_ex.alusrca ? id_ex.pc  : rs1_val;
        srcb = id_ex.alusrcb ? id_ex.imm : rs2_val;
    end

    always_comb begin
        alu_y = '0;
        case (id_ex.aluctrl)
            ALU_ADD:   alu_y = srca + srcb;
            ALU_SUB:   alu_y = srca - srcb;
            ALU_AND:   alu_y = srca & srcb;
            ALU_OR:    alu_y = srca | srcb;
            ALU_XOR:   alu_y = srca ^ srcb;
            ALU_SLL:   alu_y = srca << srcb[SH_W-1:0];
            ALU_SRL:   alu_y = srca >> srcb[SH_W-1:0];
            ALU_SRA:   alu_y = $unsigned($signed(srca) >>> srcb[SH_W-1:0]);
            ALU_SLT:   alu_y = {{(D_WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            ALU_SLTU:  alu_y = {{(D_WIDTH-1){1'b0}}, srca < srcb};
            ALU_PASSB: alu_y = srcb;
            default:   alu_y = '0;
        endcase
    end

    assign Zero   = (rs1_val == rs2_val);
    assign Less   = ($signed(rs1_val) < $signed(rs2_val));
    assign LessU  = (rs1_val < rs2_val);
    assign ALUout = alu_y;

    always_comb begin
        ex_mem_next           = '0;
        ex_mem_next.valid     = id_ex.valid;
        ex_mem_next.regwrite  = id_ex.regwrite;
        ex_mem_next.memwrite  = id_ex.memwrite;
        ex_mem_next.resultsrc = id_ex.resultsrc;
        ex_mem_next.funct3    = id_ex.funct3;
        ex_mem_next.rd        = id_ex.rd;
        ex_mem_next.alu       = alu_y;
        ex_mem_next.wdata     = rs2_val;
        ex_mem_next.inc_pc    = id_ex.inc_pc;
    end

    assign mem_idx   = ex_mem.alu[MEM_AW+1:2];
    assign byte_off  = ex_mem.alu[1:0];
    assign mem_word  = (mem_idx == TRIGGER_IDX) ? {{(D_WIDTH-1){1'b0}}, trigger} : dmem[mem_idx];
    assign load_data = load_extend(ex_mem.funct3, mem_word, byte_off);

    always_comb begin
        mem_wb_next          = '0;
        mem_wb_next.valid    = ex_mem.valid;
        mem_wb_next.regwrite = ex_mem.regwrite;
        mem_wb_next.rd       = ex_mem.rd;
        case (ex_mem.resultsrc)
            RES_ALU:  mem_wb_next.result = ex_mem.alu;
            RES_LOAD: mem_wb_next.result = load_data;
            RES_PC4:  mem_wb_next.result = ex_mem.inc_pc;
            default:  mem_wb_next.result = '0;
        endcase
    end

    // A stalled or flushed ID instruction turns into a bubble; later stages always advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if (id_valid && !id_stall && !flush)
                id_ex <= id_ex_next;
            else
                id_ex <= '0;
            ex_mem <= ex_mem_next;
            mem_wb <= mem_wb_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_we) begin
            regs[mem_wb.rd] <= mem_wb.result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ex_mem.valid && ex_mem.memwrite) begin
            case (ex_mem.funct3[1:0])
                2'b00:   dmem[mem_idx][{byte_off, 3'b000} +: 8]      <= ex_mem.wdata[7:0];
                2'b01:   dmem[mem_idx][{byte_off[1], 4'b0000} +: 16] <= ex_mem.wdata[15:0];
                default: dmem[mem_idx]                                <= ex_mem.wdata;
            endcase
        end
    end

    assign ex_valid = id_ex.valid;
    assign wb_valid = mem_wb.valid;
    assign wb_rd    = mem_wb.rd;
    assign a0       = regs[A_WIDTH'(10)];

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: issues short instruction sequences and checks
// stalls, EX results, comparator flags, WB slots and a0 against hand-computed values.
module tb_pipe_datapath;
    import datapath_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

`ifdef DATAPATH_FWD_EN
    localparam int DEP_STALLS  = 0;
    localparam int LOAD_STALLS = 1;
`else
    localparam int DEP_STALLS  = 2;
    localparam int LOAD_STALLS = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger;
    logic          id_valid;
    logic          MemWrite;
    logic          RegWrite;
    logic [3:0]    ALUctrl;
    logic          ALUSrcA;
    logic          ALUSrcB;
    logic [1:0]    ResultSrc;
    logic [2:0]    funct3_i;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [DW-1:0] ImmExt;
    logic [DW-1:0] PC_out;
    logic [DW-1:0] inc_PC;
    logic          flush;
    logic          id_stall;
    logic          ex_valid;
    logic [DW-1:0] ALUout;
    logic          Zero;
    logic          Less;
    logic          LessU;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] a0;

    int            checkCount  = 0;
    int            errorCount  = 0;
    int            stallCycles = 0;
    logic [DW-1:0] pcReg       = '0;

    pipe_datapath #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .id_valid  (id_valid),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .ALUctrl   (ALUctrl),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .funct3_i  (funct3_i),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .ImmExt    (ImmExt),
        .PC_out    (PC_out),
        .inc_PC    (inc_PC),
        .flush     (flush),
        .id_stall  (id_stall),
        .ex_valid  (ex_valid),
        .ALUout    (ALUout),
        .Zero      (Zero),
        .Less      (Less),
        .LessU     (LessU),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .a0        (a0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic regw, input logic memw, input logic [3:0] alu,
                                 input logic srcb, input logic [1:0] rsrc, input logic [2:0] f3,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] ad, input logic [DW-1:0] imm);
        id_valid  = 1'b1;
        RegWrite  = regw;
        MemWrite  = memw;
        ALUctrl   = alu;
        ALUSrcA   = 1'b0;
        ALUSrcB   = srcb;
        ResultSrc = rsrc;
        funct3_i  = f3;
        rs1       = a1;
        rs2       = a2;
        rd        = ad;
        ImmExt    = imm;
        PC_out    = pcReg;
        inc_PC    = pcReg + 32'd4;
    endtask

    // Holds the instruction in ID until accepted; returns at the negedge with it in EX.
    task automatic issueInstr(input logic regw, input logic memw, input logic [3:0] alu,
                              input logic srcb, input logic [1:0] rsrc, input logic [2:0] f3,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [AW-1:0] ad, input logic [DW-1:0] imm);
        applyStimulus(regw, memw, alu, srcb, rsrc, f3, a1, a2, ad, imm);
        stallCycles = 0;
        #1;
        while (id_stall && stallCycles < 8) begin
            stallCycles++;
            @(negedge clk);
            #1;
        end
        if (id_stall) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL stall_timeout observed=stalled expected=accepted");
        end
        @(negedge clk);
        id_valid = 1'b0;
        pcReg    = pcReg + 32'd4;
    endtask

    task automatic addi(input logic [AW-1:0] d, input logic [AW-1:0] s, input logic [DW-1:0] imm);
        issueInstr(1'b1, 1'b0, ALU_ADD, 1'b1, RES_ALU, F3_W, s, '0, d, imm);
    endtask

    task automatic addr(input logic [AW-1:0] d, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        issueInstr(1'b1, 1'b0, ALU_ADD, 1'b0, RES_ALU, F3_W, s1, s2, d, '0);
    endtask

    task automatic load(input logic [2:0] f3, input logic [AW-1:0] d, input logic [AW-1:0] s, input logic [DW-1:0] imm);
        issueInstr(1'b1, 1'b0, ALU_ADD, 1'b1, RES_LOAD, f3, s, '0, d, imm);
    endtask

    task automatic store(input logic [AW-1:0] src, input logic [AW-1:0] base, input logic [DW-1:0] imm);
        issueInstr(1'b0, 1'b1, ALU_ADD, 1'b1, RES_ALU, F3_W, base, src, '0, imm);
    endtask

    initial begin
        rst      = 1'b1;
        trigger  = 1'b0;
        flush    = 1'b0;
        applyStimulus(1'b0, 1'b0, ALU_ADD, 1'b0, RES_ALU, F3_W, '0, '0, '0, '0);
        id_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_id_stall", id_stall, 0);
        checkOutput("reset_ex_valid", ex_valid, 0);
        checkOutput("reset_wb_valid", wb_valid, 0);
        checkOutput("reset_wb_rd", wb_rd, 0);
        checkOutput("reset_a0", a0, 0);
        @(negedge clk);

        // Back-to-back dependency: addi x1,x0,5 ; add x2,x1,x1 ; addi x10,x2,0
        $display("[TB] dependent ALU chain");
        addi(5'd1, 5'd0, 32'd5);
        checkOutput("addi_aluout", ALUout, 32'd5);
        checkOutput("addi_ex_valid", ex_valid, 1);
        addr(5'd2, 5'd1, 5'd1);
        checkOutput("dep_stall_cycles", stallCycles, DEP_STALLS);
        checkOutput("add_dep_aluout", ALUout, 32'd10);
        addi(5'd10, 5'd2, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("copy_wb_valid", wb_valid, 1);
        checkOutput("copy_wb_rd", wb_rd, 10);
        @(negedge clk);
        checkOutput("a0_is_10", a0, 32'd10);

        // Comparator on forwarded values: x14=-1 vs x1=5
        $display("[TB] comparator flags");
        addi(5'd14, 5'd0, 32'hFFFF_FFFF);
        addr(5'd15, 5'd14, 5'd1);
        checkOutput("neg_add_aluout", ALUout, 32'd4);
        checkOutput("neg_zero", Zero, 0);
        checkOutput("neg_less", Less, 1);
        checkOutput("neg_lessu", LessU, 0);

        // x0 is never written and never a hazard source
        $display("[TB] x0 handling");
        addi(5'd0, 5'd0, 32'd9);
        checkOutput("x0_addi_aluout", ALUout, 32'd9);
        addr(5'd5, 5'd0, 5'd0);
        checkOutput("x0_stall_cycles", stallCycles, 0);
        checkOutput("x0_add_aluout", ALUout, 32'd0);
        checkOutput("x0_zero_flag", Zero, 1);
        addr(5'd10, 5'd5, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("a0_from_x5", a0, 32'd0);

        // Stores, load-use stall and byte load
        $display("[TB] load-use");
        addi(5'd6, 5'd0, 32'h1234);
        store(5'd6, 5'd0, 32'd0);
        addi(5'd13, 5'd0, 32'h5A);
        store(5'd13, 5'd0, 32'd4);
        load(F3_W, 5'd3, 5'd0, 32'd0);
        addr(5'd4, 5'd3, 5'd0);
        checkOutput("load_use_stall_cycles", stallCycles, LOAD_STALLS);
        checkOutput("load_use_aluout", ALUout, 32'h1234);
        checkOutput("load_use_zero", Zero, 0);
        load(F3_B, 5'd7, 5'd0, 32'd1);
        addr(5'd10, 5'd7, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("a0_lb_byte1", a0, 32'h12);

        // Flush together with a load-use stall
        $display("[TB] flush over stall");
        load(F3_W, 5'd3, 5'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, ALU_ADD, 1'b0, RES_ALU, F3_W, 5'd3, 5'd0, 5'd8, '0);
        flush = 1'b1;
        #1;
        checkOutput("flush_id_stall", id_stall, 1);
        @(negedge clk);
        flush    = 1'b0;
        id_valid = 1'b0;
        checkOutput("flush_ex_bubble", ex_valid, 0);
        @(negedge clk);
        checkOutput("flush_load_wb_valid", wb_valid, 1);
        checkOutput("flush_load_wb_rd", wb_rd, 3);
        @(negedge clk);
        checkOutput("flush_slot_wb_valid", wb_valid, 0);
        addr(5'd10, 5'd8, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("a0_x8_unwritten", a0, 32'd0);

        // Reset with three instructions in flight
        $display("[TB] mid-flight reset");
        addi(5'd10, 5'd0, 32'h55);
        store(5'd3, 5'd0, 32'd4);
        addi(5'd11, 5'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_a0", a0, 32'd0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_id_stall", id_stall, 0);
        @(negedge clk);
        addi(5'd10, 5'd0, 32'd3);
        repeat (3) @(negedge clk);
        checkOutput("post_rst_a0", a0, 32'd3);
        load(F3_W, 5'd12, 5'd0, 32'd4);
        addr(5'd10, 5'd12, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("mem_kept_over_rst", a0, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
